mem_arbiter: RTL

Parametrised N-port arbiter between the L1 caches and the shared L2 cache. It generalises the two-port instruction/data arbiter to `N_REQ` requesters, a configurable line width and a selectable fixed-priority or round-robin policy. It serialises one line-sized read or write at a time onto the single downstream port and counts contention cycles for the performance unit.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the requester-side and memory-side buses of the N-port
// L1/L2 arbiter, bundled together.
//   req_*  : N_REQ requesters (packed address/wdata, broadcast rdata,
//            one-hot resp)
//   mem_*  : the single downstream L2 port
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
interface mem_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 256
);
    logic [N_REQ-1:0]       req_read;
    logic [N_REQ-1:0]       req_write;
    logic [N_REQ*32-1:0]    req_address;
    logic [N_REQ*WIDTH-1:0] req_wdata;
    logic [WIDTH-1:0]       req_rdata;
    logic [N_REQ-1:0]       req_resp;
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            mem_address;
    logic [WIDTH-1:0]       mem_wdata;
    logic [WIDTH-1:0]       mem_rdata;
    logic                   mem_resp;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises line reads/writes from N_REQ L1 requesters onto one
// L2 port. The policy is fixed priority (MODE=0, lowest index wins) or
// round-robin (MODE=1). The block also counts IDLE cycles that see two or
// more pending requests.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus            : mem_arbiter_if.slave (requester and memory buses)
//   conflict_count : saturating contention counter
module mem_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 256,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_arbiter_if.slave       bus,
    output logic [31:0]        conflict_count
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]      conflict_q, conflict_d;

    logic [N_REQ-1:0] pend;
    logic             found;
    int               win;
    int               pcnt;
    int               idx;

    assign pend = bus.req_read | bus.req_write;

    // Winner selection and pending-request count.
    always_comb begin
        win   = 0;
        found = 1'b0;
        pcnt  = 0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pend[i]) pcnt = pcnt + 1;
        end
        if (MODE == 0) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    win   = i;
                    found = 1'b1;
                end
            end
        end else begin
            // Search starts one past the last grant and wraps. The last
            // step revisits last_q itself, so a lone requester keeps winning.
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(last_q) + k) % N_REQ;
                if (!found && pend[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        conflict_d = conflict_q;
        case (state_q)
            S_IDLE: begin
                if (pcnt >= 2 && conflict_q != 32'hFFFF_FFFF)
                    conflict_d = conflict_q + 32'd1;
                if (found) begin
                    grant_d = IW'(win);
                    last_d  = IW'(win);
                    // A read and a write on the same port are treated as a write.
                    wr_d    = bus.req_write[win];
                    rd_d    = ~bus.req_write[win];
                    addr_d  = bus.req_address[32*win +: 32];
                    wdata_d = bus.req_wdata[WIDTH*win +: WIDTH];
                    state_d = S_BUSY;
                end
            end
            default: begin
                if (bus.mem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(N_REQ - 1);
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.mem_read    = rd_q;
    assign bus.mem_write   = wr_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.req_rdata   = bus.mem_rdata;
    assign bus.req_resp    = (state_q == S_BUSY && bus.mem_resp)
                             ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign conflict_count  = conflict_q;
endmodule
